// File: rtl/sync_pkg.sv
// Shared constants and helpers for the sync_filter family of synchronisers.
package sync_pkg;

  // Fewest flops that still give a metastable first stage a full cycle to settle.
  localparam int SYNC_MIN_STAGES = 2;

  // Stability-counter width: max(1, clog2(filter)).
  // The counter only ever holds 0..filter-1, so clog2 is enough.
  function automatic int cnt_width(input int filter);
    return (filter <= 2) ? 1 : $clog2(filter);
  endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel of sync_filter: synchroniser chain, stability counter,
// filtered output level and registered rise/fall pulses.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter int   FILTER  = 4,
  parameter logic INITIAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic rise,
  output logic fall,
  output logic update
);

  localparam int            CW       = cnt_width(FILTER);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  // Reject parameter values the structure cannot honour.
  if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
    $error("sync_filter_ch: STAGES must be at least %0d", SYNC_MIN_STAGES);
  end
  if (FILTER < 1) begin : g_bad_filter
    $error("sync_filter_ch: FILTER must be at least 1");
  end

  // NOTE: declaration initialisers give FPGA power-up values matching reset;
  // ASIC flows ignore them and rely on rst.
  logic [STAGES-1:0] chain  = {STAGES{INITIAL}};
  logic [CW-1:0]     cnt    = '0;
  logic              out_q  = INITIAL;
  logic              rise_q = 1'b0;
  logic              fall_q = 1'b0;

  logic s;
  logic differ;

  assign s = chain[STAGES-1];

  // Synchroniser chain: only chain[0] may go metastable.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) chain <= {STAGES{INITIAL}};
    else     chain <= {chain[STAGES-2:0], in};
  end

  // Detect a synced value that differs from the output and has now held long enough.
  always_comb begin
    // NOTE: every always_comb output is assigned unconditionally, so no latch.
    differ = s ^ out_q;
    update = differ && (cnt == CNT_LAST);
  end

  // Stability counter, output level and edge pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      out_q  <= INITIAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= update & s;
      fall_q <= update & ~s;
      if (!differ) begin
        cnt <= '0;
      end else if (update) begin
        cnt   <= '0;
        out_q <= s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/sync_filter.sv
// Multi-channel synchroniser with glitch filter and edge detection.
// Each channel is independent; active flags any pulse in the same cycle.
module sync_filter
  import sync_pkg::*;
#(
  parameter int           N       = 1,
  parameter int           STAGES  = 2,
  parameter int           FILTER  = 4,
  parameter logic [N-1:0] INITIAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         active
);

  logic [N-1:0] update;
  logic         active_q = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_ch
    sync_filter_ch #(
      .STAGES  (STAGES),
      .FILTER  (FILTER),
      .INITIAL (INITIAL[i])
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .in     (in[i]),
      .out    (out[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .update (update[i])
    );
  end

  // active is registered from the same update terms that set rise/fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) active_q <= 1'b0;
    else     active_q <= |update;
  end

  assign active = active_q;

endmodule

// File: tb/tb_sync_filter.sv
// Self-checking bench for sync_filter: directed scenarios plus random
// stimulus against a history-window reference model.
module tb_sync_filter;

  typedef logic [3:0] vec_t;
  localparam vec_t INIT_A = 4'b0101;

  logic clk = 1'b0;
  logic rst = 1'b0;
  vec_t in_a = INIT_A;
  logic in_b = 1'b0;

  vec_t out_a, rise_a, fall_a;
  logic active_a;
  logic [0:0] out_b, rise_b, fall_b;
  logic active_b;

  int checks = 0;
  int errors = 0;

  // Reference model state: sampled-input history per DUT, newest at back.
  vec_t hist_a[$];
  vec_t hist_b[$];
  vec_t m_out_a, m_rise_a, m_fall_a;
  vec_t m_out_b, m_rise_b, m_fall_b;

  always #5 clk = ~clk;

  sync_filter #(.N(4), .STAGES(2), .FILTER(3), .INITIAL(INIT_A)) dut_a (
    .clk(clk), .rst(rst), .in(in_a), .out(out_a),
    .rise(rise_a), .fall(fall_a), .active(active_a)
  );

  sync_filter #(.N(1), .STAGES(3), .FILTER(1), .INITIAL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .out(out_b),
    .rise(rise_b), .fall(fall_b), .active(active_b)
  );

  // A channel's output flips at an edge when the synced values seen at the
  // last FILTER edges all differ from it. The synced value seen at an edge
  // is the input sampled STAGES edges earlier; before history, it is INITIAL.
  function automatic void model_edge(input vec_t hist[$], input int stages,
                                     input int filter, input int n, input vec_t init,
                                     inout vec_t o, output vec_t r, output vec_t f);
    r = '0;
    f = '0;
    for (int i = 0; i < n; i++) begin
      bit   all_diff;
      int   off;
      vec_t v;
      all_diff = 1'b1;
      for (int j = 0; j < filter; j++) begin
        off = stages - 1 + j;
        v   = (off < hist.size()) ? hist[hist.size() - 1 - off] : init;
        if (v[i] == o[i]) all_diff = 1'b0;
      end
      if (all_diff) begin
        o[i] = ~o[i];
        if (o[i]) r[i] = 1'b1;
        else      f[i] = 1'b1;
      end
    end
  endfunction

  task automatic model_reset();
    hist_a.delete();
    hist_b.delete();
    m_out_a = INIT_A; m_rise_a = '0; m_fall_a = '0;
    m_out_b = '0;     m_rise_b = '0; m_fall_b = '0;
  endtask

  // Advance one clock edge, update the model, settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      model_edge(hist_a, 2, 3, 4, INIT_A, m_out_a, m_rise_a, m_fall_a);
      hist_a.push_back(in_a);
      model_edge(hist_b, 3, 1, 1, 4'b0000, m_out_b, m_rise_b, m_fall_b);
      hist_b.push_back({3'b000, in_b});
      if (hist_a.size() > 16) hist_a.delete(0);
      if (hist_b.size() > 16) hist_b.delete(0);
    end
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    in_a = INIT_A;
    in_b = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    exp = {INIT_A, 4'b0000, 4'b0000, 1'b0};
    checks++;
    if ({out_a, rise_a, fall_a, active_a} !== exp) begin
      errors++;
      $display("FAIL reset_assert: got %b want %b", {out_a, rise_a, fall_a, active_a}, exp);
    end
    for (int e = 0; e < 2; e++) step();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if ({out_a, rise_a, fall_a, active_a} !== exp) begin
        errors++;
        $display("FAIL reset_hold e%0d: got %b want %b", e, {out_a, rise_a, fall_a, active_a}, exp);
      end
      checks++;
      if ({out_b, rise_b, fall_b, active_b} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_b e%0d: got %b want 0000", e, {out_b, rise_b, fall_b, active_b});
      end
    end
  endtask

  // in[0] 1->0 then 0->1: change lands exactly at edge STAGES+FILTER = 5.
  task automatic test_latency();
    logic [12:0] exp;
    in_a = 4'b0100;
    for (int e = 1; e <= 6; e++) begin
      step();
      exp = {(e >= 5) ? 4'b0100 : 4'b0101, 4'b0000, (e == 5) ? 4'b0001 : 4'b0000, e == 5};
      checks++;
      if ({out_a, rise_a, fall_a, active_a} !== exp) begin
        errors++;
        $display("FAIL latency_fall e%0d: got %b want %b", e, {out_a, rise_a, fall_a, active_a}, exp);
      end
    end
    in_a = 4'b0101;
    for (int e = 1; e <= 6; e++) begin
      step();
      exp = {(e >= 5) ? 4'b0101 : 4'b0100, (e == 5) ? 4'b0001 : 4'b0000, 4'b0000, e == 5};
      checks++;
      if ({out_a, rise_a, fall_a, active_a} !== exp) begin
        errors++;
        $display("FAIL latency_rise e%0d: got %b want %b", e, {out_a, rise_a, fall_a, active_a}, exp);
      end
    end
  endtask

  // in[1] high for FILTER-1 cycles: counter reaches its last value but never fires.
  task automatic test_glitch();
    logic [12:0] exp;
    exp = {4'b0101, 4'b0000, 4'b0000, 1'b0};
    in_a = 4'b0111;
    for (int e = 1; e <= 10; e++) begin
      if (e == 3) in_a = 4'b0101;
      step();
      checks++;
      if ({out_a, rise_a, fall_a, active_a} !== exp) begin
        errors++;
        $display("FAIL glitch e%0d: got %b want %b", e, {out_a, rise_a, fall_a, active_a}, exp);
      end
    end
  endtask

  // Opposite transitions on ch2/ch3 in the same cycle pulse together.
  task automatic test_simultaneous();
    logic [12:0] exp;
    in_a = 4'b1001;
    for (int e = 1; e <= 6; e++) begin
      step();
      exp = {(e >= 5) ? 4'b1001 : 4'b0101, (e == 5) ? 4'b1000 : 4'b0000,
             (e == 5) ? 4'b0100 : 4'b0000, e == 5};
      checks++;
      if ({out_a, rise_a, fall_a, active_a} !== exp) begin
        errors++;
        $display("FAIL simul_prep e%0d: got %b want %b", e, {out_a, rise_a, fall_a, active_a}, exp);
      end
    end
    in_a = 4'b0101;
    for (int e = 1; e <= 6; e++) begin
      step();
      exp = {(e >= 5) ? 4'b0101 : 4'b1001, (e == 5) ? 4'b0100 : 4'b0000,
             (e == 5) ? 4'b1000 : 4'b0000, e == 5};
      checks++;
      if ({out_a, rise_a, fall_a, active_a} !== exp) begin
        errors++;
        $display("FAIL simul e%0d: got %b want %b", e, {out_a, rise_a, fall_a, active_a}, exp);
      end
    end
  endtask

  // Reset mid-count on ch1 (INITIAL 0): counting restarts from release.
  task automatic test_reset_midcount();
    logic [12:0] exp;
    exp  = {INIT_A, 4'b0000, 4'b0000, 1'b0};
    in_a = 4'b0111;
    for (int e = 1; e <= 3; e++) step();
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({out_a, rise_a, fall_a, active_a} !== exp) begin
      errors++;
      $display("FAIL midrst_assert: got %b want %b", {out_a, rise_a, fall_a, active_a}, exp);
    end
    for (int e = 0; e < 2; e++) step();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      exp = {(e >= 5) ? 4'b0111 : 4'b0101, (e == 5) ? 4'b0010 : 4'b0000, 4'b0000, e == 5};
      checks++;
      if ({out_a, rise_a, fall_a, active_a} !== exp) begin
        errors++;
        $display("FAIL midrst e%0d: got %b want %b", e, {out_a, rise_a, fall_a, active_a}, exp);
      end
    end
  endtask

  // STAGES=3, FILTER=1: input toggles every 4 cycles, output follows 4 edges later.
  task automatic test_filter1();
    logic exp_o, exp_r, exp_f;
    int   e;
    for (int k = 0; k < 40; k++) begin
      if (k % 4 == 0) in_b = ~in_b;
      step();
      e     = k + 1;
      exp_o = ((e / 4) % 2) == 1;
      exp_r = (e % 4 == 0) && exp_o;
      exp_f = (e % 4 == 0) && !exp_o;
      checks++;
      if ({out_b, rise_b, fall_b, active_b} !== {exp_o, exp_r, exp_f, exp_r | exp_f}) begin
        errors++;
        $display("FAIL filter1 e%0d: got %b want %b", e, {out_b, rise_b, fall_b, active_b},
                 {exp_o, exp_r, exp_f, exp_r | exp_f});
      end
    end
  endtask

  // Random runs of varied length on all channels, one mid-run reset.
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(2) == 0) in_a[i] = ~in_a[i];
      if ($urandom_range(3) == 0) in_b = ~in_b;
      if (c == 200) begin
        rst = 1'b1;
        model_reset();
      end
      if (c == 202) rst = 1'b0;
      step();
      checks++;
      if ({out_a, rise_a, fall_a, active_a} !==
          {m_out_a, m_rise_a, m_fall_a, |(m_rise_a | m_fall_a)}) begin
        errors++;
        $display("FAIL random_a c%0d: got %b want %b", c, {out_a, rise_a, fall_a, active_a},
                 {m_out_a, m_rise_a, m_fall_a, |(m_rise_a | m_fall_a)});
      end
      checks++;
      if ({out_b, rise_b, fall_b, active_b} !==
          {m_out_b[0], m_rise_b[0], m_fall_b[0], m_rise_b[0] | m_fall_b[0]}) begin
        errors++;
        $display("FAIL random_b c%0d: got %b want %b", c, {out_b, rise_b, fall_b, active_b},
                 {m_out_b[0], m_rise_b[0], m_fall_b[0], m_rise_b[0] | m_fall_b[0]});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_glitch();
    test_simultaneous();
    test_reset_midcount();
    test_filter1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
